// File: rtl/if_fetch.sv
// Instruction-fetch stage: generates the fetch PC and drives the 64-bit instruction SRAM read port.
// Decode registers {pc_valid, pc} and picks the 32-bit half of the returned word using pc[2].
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic        inst_sram_en,
  output logic [7:0]  inst_sram_we,
  output logic [63:0] inst_sram_addr,
  output logic [63:0] inst_sram_wdata,
  output logic        fetch_misalign,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_reg;

  logic hold_pc;
  logic target_misaligned;
  logic fetch_accepted;

  // Only bit 0 of the stall vector concerns this stage; the other bits are for later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign hold_pc           = stall[0];
  assign target_misaligned = (br_addr[1:0] != 2'b00);
  assign fetch_accepted    = pc_valid && !hold_pc && !br_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= BOOT;
      pc             <= RESET_PC;
      pc_valid       <= 1'b0;
      fetch_misalign <= 1'b0;
      fetch_cnt      <= 64'd0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= FETCH;
          pc        <= RESET_PC;
          pc_valid  <= 1'b1;
        end

        FETCH: begin
          // A redirect outranks a stall; a misaligned target traps and parks the PC on it.
          if (br_e && target_misaligned) begin
            pc             <= br_addr;
            pc_valid       <= 1'b0;
            fetch_misalign <= 1'b1;
            state_reg      <= HALT;
          end else if (br_e) begin
            pc       <= br_addr;
            pc_valid <= 1'b1;
          end else if (!hold_pc) begin
            pc <= pc + 64'd4;
          end

          if (fetch_accepted) begin
            fetch_cnt <= fetch_cnt + 64'd1;
          end
        end

        HALT: begin
          pc_valid <= 1'b0;
        end

        default: begin
          state_reg <= BOOT;
          pc_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Whole 64-bit words are read; 0x...0 and 0x...4 re-read the same word on purpose.
  assign inst_sram_en    = pc_valid;
  assign inst_sram_addr  = {pc[63:3], 3'b000};
  assign inst_sram_we    = 8'h00;
  assign inst_sram_wdata = 64'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_fetch;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        br_e;
  logic [63:0] br_addr;
  logic        pc_valid;
  logic [63:0] pc;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_we;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;
  logic        fetch_misalign;
  logic [63:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 = booting, 1 = running, 2 = trapped.
  int          m_mode;
  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  logic        m_valid;
  logic        m_mis;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_e(br_e), .br_addr(br_addr),
    .pc_valid(pc_valid), .pc(pc), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .fetch_misalign(fetch_misalign),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic counted;
    if (rst === 1'b1) begin
      m_mode = 0; m_pc = RPC; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 64'd0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pc = RPC; m_valid = 1'b1;
    end else if (m_mode == 1) begin
      counted = m_valid && (stall[0] == 1'b0) && (br_e == 1'b0);
      if (br_e) begin
        m_pc = br_addr;
        if (br_addr % 4 != 0) begin
          m_mode = 2; m_valid = 1'b0; m_mis = 1'b1;
        end
      end else if (stall[0] == 1'b0) begin
        m_pc = m_pc + 64'd4;
      end
      if (counted) m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic [5:0] s, input logic b, input logic [63:0] a);
    rst = r; stall = s; br_e = b; br_addr = a;
  endtask

  task automatic test_reset();
    drive(1'b1, 6'h00, 1'b0, 64'd0);
    tick();
    tick();
    n_cmp++; if ({pc_valid, inst_sram_en, fetch_misalign} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {pc_valid, inst_sram_en, fetch_misalign}); end
    n_cmp++; if (pc !== RPC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RPC); end
    n_cmp++; if (fetch_cnt !== 64'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    n_cmp++; if ({inst_sram_we, inst_sram_wdata} !== 72'd0) begin n_bad++; $display("FAIL reset_we_wdata: got %h want 0", {inst_sram_we, inst_sram_wdata}); end
    $display("test_reset: pc=%h valid=%b cnt=%0d", pc, pc_valid, fetch_cnt);
  endtask

  task automatic test_boot();
    // Stall and a misaligned redirect during the boot cycle must be ignored.
    drive(1'b0, 6'h3f, 1'b1, 64'h8000_0102);
    n_cmp++; if ({pc_valid, inst_sram_en} !== 2'b00) begin n_bad++; $display("FAIL boot_cycle: got %b want 00", {pc_valid, inst_sram_en}); end
    tick();
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    n_cmp++; if ({pc_valid, inst_sram_en, fetch_misalign} !== 3'b110) begin n_bad++; $display("FAIL boot_first_flags: got %b want 110", {pc_valid, inst_sram_en, fetch_misalign}); end
    n_cmp++; if (pc !== RPC || inst_sram_addr !== RPC) begin n_bad++; $display("FAIL boot_first_pc: got pc=%h addr=%h want %h", pc, inst_sram_addr, RPC); end
    tick();
    n_cmp++; if (pc !== RPC + 64'h4 || inst_sram_addr !== RPC) begin n_bad++; $display("FAIL boot_pc4: got pc=%h addr=%h want %h/%h", pc, inst_sram_addr, RPC + 64'h4, RPC); end
    tick();
    n_cmp++; if (pc !== RPC + 64'h8 || inst_sram_addr !== RPC + 64'h8) begin n_bad++; $display("FAIL boot_pc8: got pc=%h addr=%h want %h", pc, inst_sram_addr, RPC + 64'h8); end
    n_cmp++; if (fetch_cnt !== 64'd2) begin n_bad++; $display("FAIL boot_cnt: got %0d want 2", fetch_cnt); end
    $display("test_boot: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_stall();
    tick();
    tick();
    n_cmp++; if (pc !== RPC + 64'h10 || fetch_cnt !== 64'd4) begin n_bad++; $display("FAIL stall_pre: got pc=%h cnt=%0d want %h/4", pc, fetch_cnt, RPC + 64'h10); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'h01 | 6'($urandom_range(0, 63)), 1'b0, 64'd0);
      tick();
      n_cmp++; if (pc !== RPC + 64'h10 || fetch_cnt !== 64'd4 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got pc=%h cnt=%0d valid=%b want %h/4/1", i, pc, fetch_cnt, pc_valid, RPC + 64'h10); end
    end
    drive(1'b0, 6'h3e, 1'b0, 64'd0);
    tick();
    n_cmp++; if (pc !== RPC + 64'h14 || fetch_cnt !== 64'd5) begin n_bad++; $display("FAIL stall_release: got pc=%h cnt=%0d want %h/5", pc, fetch_cnt, RPC + 64'h14); end
    tick();
    n_cmp++; if (pc !== RPC + 64'h18 || fetch_cnt !== 64'd6) begin n_bad++; $display("FAIL stall_resume: got pc=%h cnt=%0d want %h/6", pc, fetch_cnt, RPC + 64'h18); end
    $display("test_stall: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_redirect_stall();
    drive(1'b0, 6'h01, 1'b1, RPC + 64'h100);
    tick();
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    n_cmp++; if (pc !== RPC + 64'h100 || inst_sram_addr !== RPC + 64'h100 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL redir_pc: got pc=%h addr=%h valid=%b want %h", pc, inst_sram_addr, pc_valid, RPC + 64'h100); end
    n_cmp++; if (fetch_cnt !== 64'd6) begin n_bad++; $display("FAIL redir_cnt: got %0d want 6", fetch_cnt); end
    tick();
    n_cmp++; if (pc !== RPC + 64'h104 || fetch_cnt !== 64'd7) begin n_bad++; $display("FAIL redir_next: got pc=%h cnt=%0d want %h/7", pc, fetch_cnt, RPC + 64'h104); end
    $display("test_redirect_stall: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_wrap();
    drive(1'b0, 6'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    n_cmp++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst_sram_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_bad++; $display("FAIL wrap_top: got pc=%h addr=%h", pc, inst_sram_addr); end
    tick();
    n_cmp++; if (pc !== 64'd0 || inst_sram_addr !== 64'd0 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_zero: got pc=%h addr=%h valid=%b want 0/0/1", pc, inst_sram_addr, pc_valid); end
    n_cmp++; if (fetch_cnt !== 64'd8) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 8", fetch_cnt); end
    $display("test_wrap: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_misalign();
    drive(1'b0, 6'h01, 1'b1, 64'h8000_0102);
    tick();
    n_cmp++; if ({fetch_misalign, pc_valid, inst_sram_en} !== 3'b100 || pc !== 64'h8000_0102) begin n_bad++; $display("FAIL mis_trap: got flags=%b pc=%h want 100/%h", {fetch_misalign, pc_valid, inst_sram_en}, pc, 64'h8000_0102); end
    n_cmp++; if (fetch_cnt !== 64'd8) begin n_bad++; $display("FAIL mis_cnt: got %0d want 8", fetch_cnt); end
    drive(1'b0, 6'h00, 1'b1, 64'h8000_0200);
    tick();
    tick();
    n_cmp++; if ({fetch_misalign, pc_valid, inst_sram_en} !== 3'b100 || pc !== 64'h8000_0102) begin n_bad++; $display("FAIL mis_halt: got flags=%b pc=%h want 100/%h", {fetch_misalign, pc_valid, inst_sram_en}, pc, 64'h8000_0102); end
    drive(1'b1, 6'h00, 1'b0, 64'd0);
    tick();
    n_cmp++; if ({fetch_misalign, pc_valid} !== 2'b00 || pc !== RPC || fetch_cnt !== 64'd0) begin n_bad++; $display("FAIL mis_reset: got flags=%b pc=%h cnt=%0d", {fetch_misalign, pc_valid}, pc, fetch_cnt); end
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    tick();
    n_cmp++; if (pc_valid !== 1'b1 || pc !== RPC) begin n_bad++; $display("FAIL mis_restart: got valid=%b pc=%h want 1/%h", pc_valid, pc, RPC); end
    $display("test_misalign: pc=%h misalign=%b", pc, fetch_misalign);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 6'h00, 1'b1, RPC + 64'h3c);
    tick();
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    tick();
    n_cmp++; if (pc !== RPC + 64'h40 || fetch_cnt !== 64'd1) begin n_bad++; $display("FAIL rstmid_pre: got pc=%h cnt=%0d want %h/1", pc, fetch_cnt, RPC + 64'h40); end
    drive(1'b1, 6'h01, 1'b1, RPC + 64'h500);
    tick();
    drive(1'b0, 6'h00, 1'b0, 64'd0);
    n_cmp++; if ({pc_valid, inst_sram_en} !== 2'b00 || pc !== RPC || fetch_cnt !== 64'd0) begin n_bad++; $display("FAIL rstmid: got valid=%b pc=%h cnt=%0d want 0/%h/0", pc_valid, pc, fetch_cnt, RPC); end
    $display("test_reset_mid: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 600; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      drive($urandom_range(0, 40) == 0, 6'($urandom_range(0, 63)) & ($urandom_range(0, 2) == 0 ? 6'h3f : 6'h3e),
            $urandom_range(0, 5) == 0, a);
      tick();
      n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, m_pc); end
      n_cmp++; if (pc_valid !== m_valid || inst_sram_en !== m_valid) begin n_bad++; $display("FAIL rand_valid[%0d]: got valid=%b en=%b want %b", i, pc_valid, inst_sram_en, m_valid); end
      n_cmp++; if (inst_sram_addr !== (m_pc / 8) * 8) begin n_bad++; $display("FAIL rand_addr[%0d]: got %h want %h", i, inst_sram_addr, (m_pc / 8) * 8); end
      n_cmp++; if (fetch_misalign !== m_mis) begin n_bad++; $display("FAIL rand_mis[%0d]: got %b want %b", i, fetch_misalign, m_mis); end
      n_cmp++; if (fetch_cnt !== m_cnt) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, fetch_cnt, m_cnt); end
      n_cmp++; if (inst_sram_we !== 8'h00 || inst_sram_wdata !== 64'd0) begin n_bad++; $display("FAIL rand_we_wdata[%0d]: got %h/%h want 0", i, inst_sram_we, inst_sram_wdata); end
    end
    $display("test_random: 600 cycles, %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
